// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, register-file constants and the default drain depth.
package pipeline_hazard_controller_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;
    localparam int DRAIN_DEPTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        DRAIN    = 2'b10,
        HALTED   = 2'b11
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard indicators from ID/EX/MEM and the resulting pipeline control.
// The pipeline datapath is the master, the hazard controller the slave.
interface pipeline_hazard_controller_if
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] id_ex_rd;
    logic             id_ex_mem_read;
    logic             id_halt_req;
    logic             ex_mispredict;
    logic             dmem_req;
    logic             dmem_done;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             is_halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
               id_halt_req, ex_mispredict, dmem_req, dmem_done,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, is_halted, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
               id_halt_req, ex_mispredict, dmem_req, dmem_done,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, is_halted, stall_count
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Load-use hazard detection: the EX instruction is a load whose
// destination (never x0) is read by the instruction currently in ID.
module pipeline_hazard_controller_load_use_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_mem_read,
    output logic             load_use
);

    // Compare the load destination against each source operand actually read
    always_comb begin
        load_use = id_ex_mem_read && (id_ex_rd != REG_X0) &&
                   ((id_use_rs1 && (id_ex_rd == id_rs1)) ||
                    (id_use_rs2 && (id_ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline. Handles
// load-use, control, data-memory latency and the ECALL halt drain;
// forwarding-resolvable hazards are handled elsewhere.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEFAULT,
    parameter int CNT_W       = 32
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_controller_if.slave hz
);

    localparam int DW = $clog2(DRAIN_DEPTH + 1);

    hz_state_t        state;
    hz_state_t        state_next;
    logic [DW-1:0]    drain_cnt;
    logic [DW-1:0]    drain_next;
    logic             is_halted;
    logic [CNT_W-1:0] stall_count;

    logic load_use;
    logic mem_stall;
    logic freeze;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;

    pipeline_hazard_controller_load_use_detect u_load_use_detect (
        .id_rs1         (hz.id_rs1),
        .id_rs2         (hz.id_rs2),
        .id_use_rs1     (hz.id_use_rs1),
        .id_use_rs2     (hz.id_use_rs2),
        .id_ex_rd       (hz.id_ex_rd),
        .id_ex_mem_read (hz.id_ex_mem_read),
        .load_use       (load_use)
    );

    assign mem_stall = hz.dmem_req && !hz.dmem_done;

    // Per-state hazard arbitration: control outputs and next-state/drain values
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        freeze        = 1'b0;
        state_next    = state;
        drain_next    = drain_cnt;

        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                end else if (hz.ex_mispredict) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (hz.id_halt_req) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    drain_next  = DW'(DRAIN_DEPTH);
                    state_next  = DRAIN;
                end
            end
            MEM_WAIT: begin
                if (!hz.dmem_done) begin
                    freeze = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                if (mem_stall) begin
                    freeze = 1'b1;
                end else begin
                    pc_write     = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    drain_next   = drain_cnt - DW'(1);
                    if (drain_cnt == DW'(1)) begin
                        state_next = HALTED;
                    end
                end
            end
            HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end
            default: ;
        endcase

        // A memory freeze overrides whatever the state would otherwise drive
        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end
    end

    // State, drain counter, halt flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            is_halted   <= 1'b0;
            stall_count <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            is_halted <= (state_next == HALTED);
            if ((state == RUN || state == MEM_WAIT) && !pc_write && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write      = pc_write;
    assign hz.if_id_write   = if_id_write;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_write   = id_ex_write;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.ex_mem_write  = ex_mem_write;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.is_halted     = is_halted;
    assign hz.stall_count   = stall_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed scenarios
// followed by randomized traffic, checked against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int CNT_W     = 4;
    localparam int DEPTH     = 3;
    localparam int MAX_STALL = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_controller #(
        .DRAIN_DEPTH (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        bit         rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit         use1;
        bit         use2;
        logic [4:0] ex_rd;
        bit         ex_load;
        bit         halt;
        bit         mispredict;
        bit         dreq;
        bit         ddone;
    } stim_t;

    typedef struct {
        logic [6:0]  ctrl;   // pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble
        logic        halted;
        int unsigned stalls;
        int          cyc;
    } exp_t;

    typedef enum { A_NORMAL, A_FREEZE, A_REDIRECT, A_BUBBLE, A_HALT, A_DRAIN, A_STOP } act_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: what the machine is doing, not how it is encoded
    bit          m_mem_wait;
    int          m_drain_left;
    bit          m_halted;
    int unsigned m_stalls;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [6:0] ctrl_of(input act_t a);
        case (a)
            A_NORMAL:   return 7'b1101010;
            A_FREEZE:   return 7'b0000001;
            A_REDIRECT: return 7'b1111110;
            A_BUBBLE:   return 7'b0001110;
            A_HALT:     return 7'b0111010;
            A_DRAIN:    return 7'b0111110;
            default:    return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        m_mem_wait   = 1'b0;
        m_drain_left = 0;
        m_halted     = 1'b0;
        m_stalls     = 0;
    endtask

    task automatic step(input stim_t s);
        act_t a;
        bit   lu;
        bit   mstall;
        exp_t e;

        reset             = s.rst;
        hz.id_rs1         = s.rs1;
        hz.id_rs2         = s.rs2;
        hz.id_use_rs1     = s.use1;
        hz.id_use_rs2     = s.use2;
        hz.id_ex_rd       = s.ex_rd;
        hz.id_ex_mem_read = s.ex_load;
        hz.id_halt_req    = s.halt;
        hz.ex_mispredict  = s.mispredict;
        hz.dmem_req       = s.dreq;
        hz.dmem_done      = s.ddone;

        lu = s.ex_load && (s.ex_rd != 0) &&
             ((s.use1 && s.ex_rd == s.rs1) || (s.use2 && s.ex_rd == s.rs2));
        mstall = s.dreq && !s.ddone;

        if (m_halted)              a = A_STOP;
        else if (m_drain_left > 0) a = mstall ? A_FREEZE : A_DRAIN;
        else if (m_mem_wait)       a = s.ddone ? A_NORMAL : A_FREEZE;
        else if (mstall)           a = A_FREEZE;
        else if (s.mispredict)     a = A_REDIRECT;
        else if (lu)               a = A_BUBBLE;
        else if (s.halt)           a = A_HALT;
        else                       a = A_NORMAL;

        e.ctrl   = ctrl_of(a);
        e.halted = m_halted;
        e.stalls = m_stalls;
        e.cyc    = cycle;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        cycle++;

        if (s.rst) begin
            model_reset();
        end else begin
            if (!m_halted && m_drain_left == 0 && e.ctrl[6] == 1'b0 && m_stalls < MAX_STALL)
                m_stalls++;
            case (a)
                A_FREEZE: if (m_drain_left == 0) m_mem_wait = 1'b1;
                A_NORMAL: m_mem_wait = 1'b0;
                A_HALT:   m_drain_left = DEPTH;
                A_DRAIN: begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // Monitor: every cycle the DUT presents a control vector, check it
    initial begin
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
                       hz.id_ex_bubble, hz.ex_mem_write, hz.mem_wb_bubble};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl cycle %0d: got %b expected %b", e.cyc, act, e.ctrl);
                end
                checks++;
                if (hz.is_halted !== e.halted) begin
                    errors++;
                    $display("FAIL is_halted cycle %0d: got %b expected %b", e.cyc, hz.is_halted, e.halted);
                end
                checks++;
                if (hz.stall_count !== CNT_W'(e.stalls)) begin
                    errors++;
                    $display("FAIL stall_count cycle %0d: got %0d expected %0d", e.cyc, hz.stall_count, e.stalls);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        stim_t s;
        stim_t lu_s;

        reset             = 1'b1;
        hz.id_rs1         = '0;
        hz.id_rs2         = '0;
        hz.id_use_rs1     = 1'b0;
        hz.id_use_rs2     = 1'b0;
        hz.id_ex_rd       = '0;
        hz.id_ex_mem_read = 1'b0;
        hz.id_halt_req    = 1'b0;
        hz.ex_mispredict  = 1'b0;
        hz.dmem_req       = 1'b0;
        hz.dmem_done      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(idle());

        // Load-use on rs1: one bubble cycle, then clear
        lu_s = idle();
        lu_s.ex_load = 1'b1; lu_s.ex_rd = 5'd5; lu_s.rs1 = 5'd5; lu_s.use1 = 1'b1;
        step(lu_s);
        step(idle());

        // Same hazard but through rs2
        s = idle();
        s.ex_load = 1'b1; s.ex_rd = 5'd9; s.rs2 = 5'd9; s.use2 = 1'b1;
        step(s);

        // No hazard: destination x0, or operand not read
        s = lu_s; s.ex_rd = 5'd0; s.rs1 = 5'd0;
        step(s);
        s = lu_s; s.use1 = 1'b0;
        step(s);

        // Memory wait of four cycles, done on the fifth
        s = idle(); s.dreq = 1'b1;
        repeat (4) step(s);
        s.ddone = 1'b1;
        step(s);
        step(idle());

        // Mispredict beats concurrent load-use and halt
        s = lu_s; s.mispredict = 1'b1; s.halt = 1'b1;
        step(s);
        step(idle());

        // Halt, two memory-frozen drain cycles, drain to halted
        s = idle(); s.halt = 1'b1;
        step(s);
        s = idle(); s.dreq = 1'b1;
        repeat (2) step(s);
        s = idle(); s.halt = 1'b1; s.mispredict = 1'b1;
        repeat (6) step(s);

        // Reset out of HALTED, build stall_count to 7 inside a memory wait, reset there
        s = idle(); s.rst = 1'b1;
        step(s);
        s = idle(); s.dreq = 1'b1;
        repeat (7) step(s);
        s.rst = 1'b1;
        step(s);
        step(idle());

        // Saturation of the stall counter
        s = idle(); s.dreq = 1'b1;
        repeat (20) step(s);
        s.ddone = 1'b1;
        step(s);
        step(lu_s);
        step(idle());

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s            = idle();
            s.rst        = ($urandom_range(0, 99) == 0);
            s.rs1        = 5'($urandom_range(0, 3));
            s.rs2        = 5'($urandom_range(0, 3));
            s.use1       = $urandom_range(0, 1) == 1;
            s.use2       = $urandom_range(0, 1) == 1;
            s.ex_rd      = 5'($urandom_range(0, 3));
            s.ex_load    = $urandom_range(0, 1) == 1;
            s.halt       = ($urandom_range(0, 29) == 0);
            s.mispredict = ($urandom_range(0, 9) == 0);
            s.dreq       = ($urandom_range(0, 9) < 3);
            s.ddone      = $urandom_range(0, 1) == 1;
            step(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
